irq_pending_arbiter: RTL and testbench
======================================

Name: irq_pending_arbiter

Overview:
- Upstream stage of the 8-to-3 priority encode path.
- Rising-edge detects 8 raw request lines and latches them into a sticky pending register, with a per-bit mask.
- Presents the highest-priority unmasked pending index (bit 7 highest) to the downstream consumer over a valid/ready handshake.
- Clears each pending bit when its index is accepted, and counts requests lost to re-assertion while already pending.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 to match the 3-bit index.
- IDX_W, 3, index width, log2(N_REQ).
- LOST_W, 8, width of the saturating lost-request counter.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_i  input  8  raw request levels, synchronous to clk.
- mask_i  input  8  1 = bit not eligible for offer; the bit still latches as pending.
- out_valid  output  1  an index is offered.
- out_idx  output  3  offered index, 7 = highest priority.
- out_ready  input  1  consumer accepts when out_valid&out_ready.
- pending_o  output  8  current pending register.
- lost_cnt  output  LOST_W  saturating count of dropped edges.

Behaviour:
- Reset (async assert, release on clk): the following all go to 0.
  - pending, req_prev, out_valid, out_idx, lost_cnt.
  - FSM goes to IDLE.
  - Because req_prev resets to 0, a line held high through reset release registers as one edge on the first clock.
- Edge detect: edge = req_i & ~req_prev; req_prev <= req_i every cycle.
- Pending update, per bit i, each cycle:
  - set_i = edge[i].
  - clr_i = accept & (out_idx==i), where accept = out_valid & out_ready.
  - pending[i] <= set_i | (pending[i] & ~clr_i).
  - Set wins over clear in the same cycle: the bit re-pends and is offered again later.
- Lost count: lost_cnt increments by the number of bits with edge[i] & pending[i] & ~clr_i.
  - Adds 0..8 per cycle.
  - Saturates at 2^LOST_W-1 and never wraps.
- Eligibility: elig = pending & ~mask_i.
  - Priority select over elig, MSB wins.
  - An all-zero elig means nothing is offered.
- FSM with 2 states:
  - IDLE: out_valid=0. If elig != 0, then out_idx <= highest set bit of elig, out_valid <= 1, go to OFFER. Otherwise stay.
  - OFFER: out_valid=1 and out_idx held stable; no revoke even if mask_i or pending changes.
    - On accept: out_valid <= 0, go to IDLE.
    - Otherwise stay.
  - A one-cycle bubble after every accept is mandatory.
  - Sustained throughput: 1 index per 2 cycles.
- Latency:
  - req_i rises before clk edge k → pending visible after edge k → out_valid=1 after edge k+1.
  - Total: 2 cycles, mask open, FSM IDLE.
- Offered bit masked during OFFER: the offer completes normally and the bit clears on accept.
- pending_o is the registered pending value; it shows the clear one cycle after accept.
- No combinational path from out_ready to out_valid or out_idx.
- Reset asserted mid-OFFER: out_valid drops immediately (async) and all pending is lost; lost_cnt is not incremented.

Decomposition:
- Shared package holds:
  - constants N_REQ=8, IDX_W=3;
  - FSM state enum {IDLE, OFFER};
  - a function msb_index(8-bit) returning a 3-bit index. It is the same priority rule as the downstream encoder, so both use identical semantics.
- One natural sub-module: irq_edge_latch, holding req_prev, the edge/pending set-clear logic and the lost counter.
- The top holds the priority select and the handshake FSM.

Test Plan:
- Reset release with req_i=8'h00, then pulse req_i=8'h12 for 1 cycle with out_ready=1 → pending_o=8'h12; out_idx=4 at cycle+2 accepted, then out_idx=1 two cycles later; pending_o=8'h00 and lost_cnt=0 at the end.
- mask_i=8'h80, req_i edge on bits 7 and 0 → offer idx 0 only, bit 7 stays pending. Clearing mask_i then gives idx 7.
- out_ready=0 for 10 cycles while offering idx 3, and a new edge on bit 6 arrives → out_idx remains 3 and out_valid stays 1 throughout; after ready, next offer is 6.
- Re-pulse bit 2 while pending (unaccepted) 3 times → lost_cnt=3. Edge on bit 2 in the exact accept cycle → pending[2]=1 afterwards, lost_cnt unchanged.
- Force 8 lost edges per cycle for 40 cycles with LOST_W=8 → lost_cnt saturates at 255.
- req_i held 8'hFF through reset; assert rst mid-OFFER → out_valid=0 immediately, pending_o=0. After release, one edge per line is detected and indices 7..0 are offered in order.

Source files
------------

// File: rtl/irq_pending_arbiter_pkg.sv
// Shared definitions for the interrupt pending arbiter path: sizes, the
// handshake FSM states and the MSB-first priority rule that the downstream
// 8-to-3 encoder also uses.
package irq_pending_arbiter_pkg;

    // Number of request lines; tied to the 3-bit index width.
    localparam int N_REQ = 8;

    // Index width, log2(N_REQ).
    localparam int IDX_W = 3;

    // Default width of the saturating lost-request counter.
    localparam int LOST_W_DEF = 8;

    // Offer handshake states.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Highest set bit of vec (bit 7 wins). Returns 0 for an all-zero vector;
    // callers must qualify with |vec before trusting the result.
    function automatic logic [IDX_W-1:0] msb_index(input logic [N_REQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        // Scan upward so that the last set bit seen is the most significant.
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage : irq_pending_arbiter_pkg

// File: rtl/irq_edge_latch.sv
// Rising-edge detector plus sticky pending register for the request lines.
// Each newly seen edge sets its pending bit; an accepted index clears it.
// An edge arriving on a bit that is already pending (and not being cleared in
// that same cycle) cannot be recorded separately, so it is counted as lost in
// a saturating counter.
module irq_edge_latch
    import irq_pending_arbiter_pkg::*;
#(
    parameter int LOST_W = LOST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req_i,
    input  logic [N_REQ-1:0]  clr,
    output logic [N_REQ-1:0]  pending,
    output logic [LOST_W-1:0] lost_cnt
);

    // Headroom for adding up to N_REQ lost edges before saturation.
    localparam int CNT_W = 4;
    localparam int SUM_W = LOST_W + CNT_W;

    logic [N_REQ-1:0]  req_prev_reg;
    logic [N_REQ-1:0]  pending_reg;
    logic [N_REQ-1:0]  pending_next;
    logic [N_REQ-1:0]  rise;
    logic [N_REQ-1:0]  lost_v;
    logic [LOST_W-1:0] lost_reg;
    logic [LOST_W-1:0] lost_next;
    logic [CNT_W-1:0]  lost_add;
    logic [SUM_W-1:0]  lost_sum;

    // Per-bit edge detect, set/clear and lost-edge qualification.
    // A set beats a clear in the same cycle: the bit re-pends and will be
    // offered again, so such an edge is not lost.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bit
            assign rise[gi]         = req_i[gi] & ~req_prev_reg[gi];
            assign lost_v[gi]       = rise[gi] & pending_reg[gi] & ~clr[gi];
            assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~clr[gi]);
        end
    endgenerate

    // Count lost edges this cycle and add them with saturation.
    always_comb begin
        lost_add = '0;
        for (int i = 0; i < N_REQ; i++) begin
            lost_add = lost_add + {{(CNT_W-1){1'b0}}, lost_v[i]};
        end
        lost_sum = {{CNT_W{1'b0}}, lost_reg} + {{LOST_W{1'b0}}, lost_add};
        if (lost_sum > {{CNT_W{1'b0}}, {LOST_W{1'b1}}}) begin
            lost_next = {LOST_W{1'b1}};
        end else begin
            lost_next = lost_sum[LOST_W-1:0];
        end
    end

    // Edge history, pending register and lost counter. req_prev resets to 0
    // so a line already high at reset release counts as one fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev_reg <= '0;
            pending_reg  <= '0;
            lost_reg     <= '0;
        end else begin
            req_prev_reg <= req_i;
            pending_reg  <= pending_next;
            lost_reg     <= lost_next;
        end
    end

    assign pending  = pending_reg;
    assign lost_cnt = lost_reg;

endmodule : irq_edge_latch

// File: rtl/irq_pending_arbiter.sv
// Upstream stage of the 8-to-3 priority encode path. Latches request edges
// into a sticky pending set and offers the highest-priority unmasked pending
// index over a valid/ready handshake. The offer is held stable until
// accepted, and every accept is followed by a one-cycle bubble, so all
// outputs come straight from registers with no path from out_ready.
module irq_pending_arbiter
    import irq_pending_arbiter_pkg::*;
#(
    parameter int LOST_W = LOST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req_i,
    input  logic [N_REQ-1:0]  mask_i,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    input  logic              out_ready,
    output logic [N_REQ-1:0]  pending_o,
    output logic [LOST_W-1:0] lost_cnt
);

    state_t            state_reg;
    logic              valid_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              accept;
    logic [N_REQ-1:0]  clr;
    logic [N_REQ-1:0]  pending;
    logic [N_REQ-1:0]  elig;

    // A handshake completes only while an offer is actually up.
    assign accept = valid_reg & out_ready;

    // One-hot clear for the index being accepted this cycle.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_clr
            assign clr[gi] = accept & (idx_reg == IDX_W'(gi));
        end
    endgenerate

    irq_edge_latch #(
        .LOST_W   (LOST_W)
    ) u_edge_latch (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .clr      (clr),
        .pending  (pending),
        .lost_cnt (lost_cnt)
    );

    // Masked bits stay pending; they are simply not eligible for an offer.
    assign elig = pending & ~mask_i;

    // Handshake FSM: pick the highest eligible index in IDLE, then hold it in
    // OFFER until accepted. Mask or pending changes never revoke an offer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|elig) begin
                        idx_reg   <= msb_index(elig);
                        valid_reg <= 1'b1;
                        state_reg <= OFFER;
                    end
                end
                OFFER: begin
                    if (out_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = valid_reg;
    assign out_idx   = idx_reg;
    assign pending_o = pending;

endmodule : irq_pending_arbiter

// File: tb/tb_irq_pending_arbiter.sv
// Directed bench for irq_pending_arbiter: a table of per-cycle vectors for the
// offer/accept, mask, stall and lost-count sequences, followed by hand-written
// sequences for counter saturation and reset during an offer.
module tb_irq_pending_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req_i;
    logic [7:0] mask_i;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_ready;
    logic [7:0] pending_o;
    logic [7:0] lost_cnt;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_idx;
        logic [7:0] exp_pend;
        logic [7:0] exp_lost;
    } vec_t;

    vec_t vt[64];
    int   nv;

    irq_pending_arbiter #(
        .LOST_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .mask_i    (mask_i),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pending_o (pending_o),
        .lost_cnt  (lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] r, input logic [7:0] m, input logic rd,
                       input logic v, input logic [2:0] ix, input logic [7:0] p,
                       input logic [7:0] l);
        vt[nv] = '{req: r, mask: m, ready: rd, exp_valid: v, exp_idx: ix,
                   exp_pend: p, exp_lost: l};
        nv++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_lost;
        n_vec = 0;
        n_bad = 0;
        nv    = 0;

        // Each row: inputs applied before an edge, outputs expected after it.
        // Two-index drain: 0x12 -> idx 4, bubble, idx 1.
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'd0);
        add(8'h12, 8'h00, 1'b1, 1'b0, 3'd0, 8'h12, 8'd0);
        add(8'h00, 8'h00, 1'b1, 1'b1, 3'd4, 8'h12, 8'd0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd4, 8'h02, 8'd0);
        add(8'h00, 8'h00, 1'b1, 1'b1, 3'd1, 8'h02, 8'd0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 8'd0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 8'd0);
        // Mask bit 7: idx 0 served first, then 7 once unmasked.
        add(8'h81, 8'h80, 1'b1, 1'b0, 3'd1, 8'h81, 8'd0);
        add(8'h81, 8'h80, 1'b1, 1'b1, 3'd0, 8'h81, 8'd0);
        add(8'h81, 8'h80, 1'b1, 1'b0, 3'd0, 8'h80, 8'd0);
        add(8'h81, 8'h80, 1'b1, 1'b0, 3'd0, 8'h80, 8'd0);
        add(8'h81, 8'h00, 1'b1, 1'b1, 3'd7, 8'h80, 8'd0);
        add(8'h81, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 8'd0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 8'd0);
        // Stall on idx 3 for 10 cycles while bit 6 arrives.
        add(8'h08, 8'h00, 1'b0, 1'b0, 3'd7, 8'h08, 8'd0);
        add(8'h08, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 8'd0);
        add(8'h48, 8'h00, 1'b0, 1'b1, 3'd3, 8'h48, 8'd0);
        for (int i = 0; i < 8; i++) begin
            add(8'h48, 8'h00, 1'b0, 1'b1, 3'd3, 8'h48, 8'd0);
        end
        add(8'h48, 8'h00, 1'b1, 1'b0, 3'd3, 8'h40, 8'd0);
        add(8'h48, 8'h00, 1'b1, 1'b1, 3'd6, 8'h40, 8'd0);
        add(8'h48, 8'h00, 1'b1, 1'b0, 3'd6, 8'h00, 8'd0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd6, 8'h00, 8'd0);
        // Bit 2 re-pulsed three times while pending and masked.
        add(8'h04, 8'h04, 1'b0, 1'b0, 3'd6, 8'h04, 8'd0);
        add(8'h00, 8'h04, 1'b0, 1'b0, 3'd6, 8'h04, 8'd0);
        add(8'h04, 8'h04, 1'b0, 1'b0, 3'd6, 8'h04, 8'd1);
        add(8'h00, 8'h04, 1'b0, 1'b0, 3'd6, 8'h04, 8'd1);
        add(8'h04, 8'h04, 1'b0, 1'b0, 3'd6, 8'h04, 8'd2);
        add(8'h00, 8'h04, 1'b0, 1'b0, 3'd6, 8'h04, 8'd2);
        add(8'h04, 8'h04, 1'b0, 1'b0, 3'd6, 8'h04, 8'd3);
        // Unmask, then an edge on bit 2 in the very accept cycle re-pends it.
        add(8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 8'h04, 8'd3);
        add(8'h04, 8'h00, 1'b1, 1'b0, 3'd2, 8'h04, 8'd3);
        add(8'h04, 8'h00, 1'b1, 1'b1, 3'd2, 8'h04, 8'd3);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 8'd3);

        // Reset with all inputs quiet, checked while reset is held.
        rst       = 1'b1;
        req_i     = 8'h00;
        mask_i    = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.idx", 32'(out_idx), 32'd0);
        check("rst.pend", 32'(pending_o), 32'h00);
        check("rst.lost", 32'(lost_cnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < nv; i++) begin
            req_i     = vt[i].req;
            mask_i    = vt[i].mask;
            out_ready = vt[i].ready;
            tick();
            check($sformatf("v%0d.valid", i), 32'(out_valid), 32'(vt[i].exp_valid));
            check($sformatf("v%0d.idx", i), 32'(out_idx), 32'(vt[i].exp_idx));
            check($sformatf("v%0d.pend", i), 32'(pending_o), 32'(vt[i].exp_pend));
            check($sformatf("v%0d.lost", i), 32'(lost_cnt), 32'(vt[i].exp_lost));
        end

        // Saturation: all eight lines re-pulsed while pending, nothing offered.
        exp_lost  = 8'd3;
        mask_i    = 8'hFF;
        out_ready = 1'b0;
        for (int e = 0; e < 40; e++) begin
            req_i = 8'hFF;
            tick();
            if (e > 0) begin
                exp_lost = (int'(exp_lost) + 8 > 255) ? 8'd255 : exp_lost + 8'd8;
            end
            check($sformatf("sat%0d.lost", e), 32'(lost_cnt), 32'(exp_lost));
            check($sformatf("sat%0d.pend", e), 32'(pending_o), 32'hFF);
            req_i = 8'h00;
            tick();
        end
        check("sat.final", 32'(lost_cnt), 32'd255);

        // Hold all lines high, open the mask and get an offer up.
        req_i = 8'hFF;
        tick();
        check("sat.hold", 32'(lost_cnt), 32'd255);
        mask_i = 8'h00;
        tick();
        check("mid.valid", 32'(out_valid), 32'd1);
        check("mid.idx", 32'(out_idx), 32'd7);

        // Asynchronous reset in the middle of the offer.
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid", 32'(out_valid), 32'd0);
        check("arst.pend", 32'(pending_o), 32'h00);
        check("arst.lost", 32'(lost_cnt), 32'd0);
        tick();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;

        // Lines held high across reset give one edge each, drained 7..0.
        tick();
        check("rel.pend", 32'(pending_o), 32'hFF);
        check("rel.valid", 32'(out_valid), 32'd0);
        for (int i = 7; i >= 0; i--) begin
            tick();
            check($sformatf("drain%0d.valid", i), 32'(out_valid), 32'd1);
            check($sformatf("drain%0d.idx", i), 32'(out_idx), 32'(i));
            tick();
            check($sformatf("drain%0d.bubble", i), 32'(out_valid), 32'd0);
            check($sformatf("drain%0d.pend", i), 32'(pending_o), (32'd1 << i) - 32'd1);
        end
        check("drain.lost", 32'(lost_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_irq_pending_arbiter
